// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed little-endian byte
// stream, writes it word by word into instruction memory and holds the
// single-cycle core in reset until the whole program has been written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        load_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  // Idle counter must be able to hold the value TIMEOUT itself.
  localparam int            IW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);
  localparam logic [31:0]   MAX_N      = MAX_WORDS;

  logic [2:0]    state;
  logic [15:0]   index;
  logic [15:0]   n_words;
  logic [1:0]    bcnt;
  logic [IW-1:0] idle;
  logic [31:0]   word;

  logic          accept;
  logic [15:0]   hdr_n;
  logic          hdr_bad;
  logic [IW-1:0] idle_inc;
  logic          idle_expired;
  logic [15:0]   index_inc;

  assign accept       = in_valid & in_ready;
  // Full count as it will look once the high byte currently on in_data lands.
  assign hdr_n        = {in_data, n_words[7:0]};
  assign hdr_bad      = (hdr_n == 16'd0) || ({16'd0, hdr_n} > MAX_N);
  assign idle_inc     = idle + IW'(1);
  assign idle_expired = (idle_inc == IDLE_LIMIT);
  assign index_inc    = index + 16'd1;

  // A load request in the WRITE cycle cancels that write outright.
  assign mem_we    = (state == WRITE) && !load_req;
  assign mem_addr  = BASE_ADDR + {14'd0, index, 2'b00};
  assign mem_wdata = word;

  // Handshake and status outputs decoded from the current state only, so
  // they follow the asynchronous reset without waiting for a clock.
  always_comb begin
    in_ready = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      HDR0, HDR1, DATA: in_ready = 1'b1;
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ERR: begin
        in_ready = 1'b1;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

  // Load sequencer: header capture, word assembly, write issue, idle timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HDR0;
      index   <= 16'd0;
      n_words <= 16'd0;
      bcnt    <= 2'd0;
      idle    <= '0;
      word    <= 32'd0;
    end else if (load_req) begin
      // Restart wins over any byte or write in the same cycle.
      state <= HDR0;
      index <= 16'd0;
      bcnt  <= 2'd0;
      idle  <= '0;
    end else begin
      case (state)
        HDR0: begin
          if (accept) begin
            n_words[7:0] <= in_data;
            idle         <= '0;
            state        <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_words[15:8] <= in_data;
            idle          <= '0;
            if (hdr_bad) begin
              state <= ERR;
            end else begin
              index <= 16'd0;
              bcnt  <= 2'd0;
              state <= DATA;
            end
          end else if (idle_expired) begin
            idle  <= '0;
            state <= ERR;
          end else begin
            idle <= idle_inc;
          end
        end
        DATA: begin
          if (accept) begin
            // First byte of a word ends up in bits [7:0] after four shifts.
            word <= {in_data, word[31:8]};
            idle <= '0;
            if (bcnt == 2'd3) begin
              bcnt  <= 2'd0;
              state <= WRITE;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end else if (idle_expired) begin
            idle  <= '0;
            state <= ERR;
          end else begin
            idle <= idle_inc;
          end
        end
        WRITE: begin
          index <= index_inc;
          idle  <= '0;
          if (index_inc == n_words) begin
            state <= DONE;
          end else begin
            state <= DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, 256, largest accepted program length in 32-bit words (instruction memory depth).
REQ-003 Parameter TIMEOUT, 65535, idle cycles allowed between bytes once a load has started.
REQ-004 Ports: clk input 1, the single clock, all state on its rising edge.
REQ-005 Ports: rst input 1, asynchronous active-low reset.
REQ-006 Ports: in_valid input 1, a byte is offered on in_data.
REQ-007 Ports: in_data input 8, the serial program byte stream.
REQ-008 Ports: in_ready output 1, the loader accepts in_data this cycle.
REQ-009 Ports: load_req input 1, a one-cycle pulse that restarts loading and holds the core in reset.
REQ-010 Ports: mem_we output 1, instruction memory write strobe.
REQ-011 Ports: mem_addr output 32, instruction memory byte address, word-aligned.
REQ-012 Ports: mem_wdata output 32, instruction word to write.
REQ-013 Ports: core_rst output 1, active-high reset to the single-cycle core.
REQ-014 Ports: done output 1, program loaded and core released.
REQ-015 Ports: err output 1, load aborted.

Function
REQ-016 A byte transfers only on a rising edge with in_valid=1 and in_ready=1; otherwise it does not transfer.
REQ-017 Stream format: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte goes to bits [7:0]).
REQ-018 States: HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-019 HDR0: in_ready=1. An accepted byte becomes the count low byte, then HDR1.
REQ-020 HDR1: in_ready=1. An accepted byte becomes the count high byte. If N=0 or N>MAX_WORDS, go to ERR; otherwise go to DATA with word index=0 and byte counter=0.
REQ-021 DATA: in_ready=1. Each accepted byte shifts into the word assembler. On the 4th byte, go to WRITE.
REQ-022 WRITE, exactly one cycle: mem_we=1, in_ready=0, mem_addr=BASE_ADDR+4*index, mem_wdata=assembled word. The index then increments. If the new index equals N, go to DONE; otherwise go to DATA.
REQ-023 mem_we is 0 in every state other than WRITE. mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-024 core_rst=1 in every state except DONE. In DONE: core_rst=0, done=1, in_ready=0.
REQ-025 ERR: err=1, core_rst=1, in_ready=1. Accepted bytes are discarded, and no memory writes occur.
REQ-026 Timeout, active in HDR1 and DATA only:
  - an idle counter resets to 0 on every accepted byte and on each state entry;
  - it increments on every other cycle;
  - when it reaches TIMEOUT, go to ERR.
  The idle counter is held in HDR0, WRITE, DONE and ERR.
REQ-027 load_req=1 in any state goes to HDR0 on the next edge, clearing index, byte counter, done and err, and asserting core_rst.
  - load_req has priority over a byte accepted in the same cycle; that byte is dropped.
  - load_req has priority over a pending WRITE; the write is suppressed.
REQ-028 The index and N are 16 bits. The address arithmetic is 32-bit modulo 2^32.
REQ-029 Latency: WRITE is asserted in the cycle after the 4th byte of a word is accepted. DONE is entered on the edge after the last WRITE cycle.

Reset
REQ-030 While rst=0, asynchronously:
  - state=HDR0, index=0, byte counter=0, idle counter=0;
  - core_rst=1, in_ready=1, mem_we=0, done=0, err=0;
  - mem_addr=BASE_ADDR, mem_wdata=0.
REQ-031 Reset asserted mid-load abandons the partial load. No write is issued after reset deasserts until a full word is received under a fresh header.

Verification
REQ-032 Bytes 02 00 13 05 A0 00 93 05 B0 00, with in_valid held high, produce:
  - write 0x00A00513 at address 0x0, then 0x00B00593 at address 0x4;
  - then done=1 and core_rst=0.
REQ-033 Back-pressure: in_valid held high across WRITE cycles. in_ready=0 during WRITE, no byte is lost, and the written words match the stream exactly.
REQ-034 Header 00 00 gives err=1 with no mem_we. Header 01 01 (N=257 > 256) gives err=1. Both hold core_rst=1.
REQ-035 Header 01 00 followed by 2 bytes, then silence for TIMEOUT cycles (set TIMEOUT=16 in the bench), gives err=1 at cycle 16 with no mem_we.
REQ-036 From DONE, a load_req pulse gives core_rst=1 and done=0 on the next edge. A second program then loads from BASE_ADDR and overwrites the first.
REQ-037 Drive rst=0 between clock edges during DATA. All outputs take their reset values immediately, without waiting for clk; a subsequent full load completes normally.
